// File: rtl/platform_scroll_scheduler_if.sv
// Signal bundle between the scroll scheduler, frame timing, doodle physics,
// LFSR and the platform table slot port.
interface platform_scroll_scheduler_if;
    logic               frame_start;
    logic [9:0]         doodle_y;
    logic [15:0]        rnd;
    logic [6:0]         rd_idx;
    logic signed [10:0] rd_y;
    logic               wr_we;
    logic [6:0]         wr_idx;
    logic signed [10:0] wr_y;
    logic               wr_active;
    logic               wr_act_we;
    logic               busy;
    logic               done;
    logic [5:0]         shift_amt;
    logic [19:0]        scroll_total;
    logic               frame_overrun;

    modport master (
        input  frame_start, doodle_y, rnd, rd_y,
        output rd_idx, wr_we, wr_idx, wr_y, wr_active, wr_act_we,
               busy, done, shift_amt, scroll_total, frame_overrun
    );

    modport slave (
        output frame_start, doodle_y, rnd, rd_y,
        input  rd_idx, wr_we, wr_idx, wr_y, wr_active, wr_act_we,
               busy, done, shift_amt, scroll_total, frame_overrun
    );
endinterface

// File: rtl/platform_scroll_scheduler.sv
// Per-frame scroll controller: picks a scroll step from doodle height, then shifts every
// platform slot down through a read-modify-write pass, recycling slots that leave the screen.
module platform_scroll_scheduler #(
    parameter int unsigned NRows      = 31,
    parameter int unsigned Cols       = 3,
    parameter int unsigned RowPitch   = 30,
    parameter int unsigned ScreenH    = 768,
    parameter int unsigned ScrollLine = 300,
    parameter int unsigned MaxStep    = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    platform_scroll_scheduler_if.master bus_io
);

    localparam int unsigned NumSlots = NRows * Cols;
    localparam int unsigned ColW     = (Cols > 1) ? $clog2(Cols) : 1;

    localparam logic [6:0]         LastIdx = 7'(NumSlots - 1);
    localparam logic [ColW-1:0]    LastCol = ColW'(Cols - 1);
    localparam logic signed [10:0] ScreenY = 11'(ScreenH);
    localparam logic signed [10:0] WrapY   = 11'(NRows * RowPitch);

    typedef enum logic [2:0] {StIdle, StCalc, StScan, StDrain, StDone} state_e;

    state_e          state_q;
    logic [6:0]      rd_idx_q;
    logic [ColW-1:0] rd_col_q;
    logic            wr_vld_q;
    logic [6:0]      wr_idx_q;
    logic [ColW-1:0] wr_col_q;
    logic [Cols-1:0] row_bits_q;
    logic [5:0]      shift_q;
    logic [19:0]     total_q;
    logic            busy_q;
    logic            done_q;
    logic            overrun_q;

    logic [9:0]         line_diff;
    logic [5:0]         calc_shift;
    logic [20:0]        total_sum;
    logic [19:0]        total_d;
    logic signed [10:0] ny;
    logic               recycle;
    logic [Cols-1:0]    row_bits_cur;
    logic               earlier_active;
    logic               slot_active;
    logic               unused_rnd;

    assign unused_rnd = ^bus_io.rnd[15:Cols];

    assign line_diff  = 10'(ScrollLine) - bus_io.doodle_y;
    assign calc_shift = (bus_io.doodle_y >= 10'(ScrollLine)) ? 6'd0 :
                        (line_diff > 10'(MaxStep))             ? 6'(MaxStep) :
                                                                  line_diff[5:0];

    assign total_sum = {1'b0, total_q} + {15'd0, shift_q};
    assign total_d   = total_sum[20] ? '1 : total_sum[19:0];

    // Write stage: rd_y belongs to the slot whose address was issued last cycle.
    assign ny      = bus_io.rd_y + $signed({5'd0, shift_q});
    assign recycle = wr_vld_q && (ny >= ScreenY);

    // Column 0 of a recycled row uses the live LFSR value; later columns use the latched copy.
    assign row_bits_cur = (wr_col_q == '0) ? bus_io.rnd[Cols-1:0] : row_bits_q;

    always_comb begin
        earlier_active = 1'b0;
        for (int unsigned i = 0; i < Cols; i++) begin
            if (i < 32'(wr_col_q)) begin
                earlier_active = earlier_active | row_bits_cur[i];
            end
        end
        slot_active = row_bits_cur[wr_col_q];
        if (wr_col_q == LastCol && !earlier_active) begin
            slot_active = 1'b1;
        end
    end

    assign bus_io.rd_idx        = rd_idx_q;
    assign bus_io.wr_we         = wr_vld_q;
    assign bus_io.wr_idx        = wr_idx_q;
    assign bus_io.wr_y          = !wr_vld_q ? 11'sd0 : (recycle ? ny - WrapY : ny);
    assign bus_io.wr_act_we     = recycle;
    assign bus_io.wr_active     = recycle & slot_active;
    assign bus_io.busy          = busy_q;
    assign bus_io.done          = done_q;
    assign bus_io.shift_amt     = shift_q;
    assign bus_io.scroll_total  = total_q;
    assign bus_io.frame_overrun = overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rd_idx_q   <= '0;
            rd_col_q   <= '0;
            wr_vld_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_col_q   <= '0;
            row_bits_q <= '0;
            shift_q    <= '0;
            total_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            wr_vld_q <= 1'b0;
            if (bus_io.frame_start && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
            if (recycle && wr_col_q == '0) begin
                row_bits_q <= bus_io.rnd[Cols-1:0];
            end
            unique case (state_q)
                StIdle: begin
                    if (bus_io.frame_start) begin
                        state_q <= StCalc;
                        busy_q  <= 1'b1;
                    end
                end
                StCalc: begin
                    shift_q  <= calc_shift;
                    rd_idx_q <= '0;
                    rd_col_q <= '0;
                    if (calc_shift == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    wr_vld_q <= 1'b1;
                    wr_idx_q <= rd_idx_q;
                    wr_col_q <= rd_col_q;
                    rd_col_q <= (rd_col_q == LastCol) ? '0 : rd_col_q + 1'b1;
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_q <= '0;
                        state_q  <= StDrain;
                    end else begin
                        rd_idx_q <= rd_idx_q + 7'd1;
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    total_q <= total_d;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_platform_scroll_scheduler.sv
// Self-checking bench for platform_scroll_scheduler: a table model feeds rd_y, and a
// scoreboard of expected slot writes is checked against every DUT write strobe.
module tb_platform_scroll_scheduler;

    localparam int Slots = 93;

    typedef struct packed {
        logic [6:0]  idx;
        logic [10:0] y;
        logic        awe;
        logic        act;
    } wr_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    platform_scroll_scheduler_if bus ();

    platform_scroll_scheduler dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus_io (bus.master)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int exp_total = 0;

    wr_t sb[$];

    logic signed [10:0] mem     [Slots];
    logic signed [10:0] model_y [Slots];
    logic signed [10:0] init_y  [Slots];
    logic               load_en = 1'b0;
    logic [6:0]         load_idx = '0;
    logic signed [10:0] load_val = '0;

    always @(posedge clk) begin
        bus.rd_y <= mem[bus.rd_idx];
        if (load_en) mem[load_idx] <= load_val;
        else if (bus.wr_we) mem[bus.wr_idx] <= bus.wr_y;
    end

    // Scoreboard checker: every write strobe must match the next expected slot update.
    always @(negedge clk) begin
        if (rst_ni && bus.wr_we) begin
            wr_t got, exp;
            got.idx = bus.wr_idx;
            got.y   = bus.wr_y;
            got.awe = bus.wr_act_we;
            got.act = bus.wr_act_we ? bus.wr_active : 1'b0;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write: got idx=%0d y=%0d, required no write",
                         got.idx, $signed(got.y));
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL slot_write: got idx=%0d y=%0d awe=%b act=%b, required idx=%0d y=%0d awe=%b act=%b",
                             got.idx, $signed(got.y), got.awe, got.act,
                             exp.idx, $signed(exp.y), exp.awe, exp.act);
                end
            end
        end
    end

    function automatic logic [56:0] all_outputs();
        return {bus.rd_idx, bus.wr_we, bus.wr_idx, bus.wr_y, bus.wr_active, bus.wr_act_we,
                bus.busy, bus.done, bus.shift_amt, bus.scroll_total, bus.frame_overrun};
    endfunction

    task automatic load_table(input int base);
        for (int k = 0; k < Slots; k++) begin
            @(negedge clk);
            load_en  = 1'b1;
            load_idx = 7'(k);
            load_val = 11'(base + 30 * (k / 3));
            model_y[k] = 11'(base + 30 * (k / 3));
            init_y[k]  = 11'(base + 30 * (k / 3));
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Reference model: derive the pass's shift and push every expected write.
    task automatic push_expected(input int dy, input logic [15:0] r, output int sh);
        sh = (dy < 300) ? ((300 - dy > 32) ? 32 : 300 - dy) : 0;
        if (sh != 0) begin
            for (int k = 0; k < Slots; k++) begin
                int  ny, ey, col;
                bit  rec;
                wr_t e;
                ny  = int'(model_y[k]) + sh;
                rec = (ny >= 768);
                ey  = rec ? ny - 930 : ny;
                col = k % 3;
                e.idx = 7'(k);
                e.y   = 11'(ey);
                e.awe = rec;
                if (!rec) e.act = 1'b0;
                else if (col < 2) e.act = r[col];
                else e.act = r[2] | ~(r[0] | r[1]);
                sb.push_back(e);
                model_y[k] = 11'(ey);
            end
        end
        exp_total += sh;
    endtask

    // Pulse frame_start and count cycles until done (cycle 0 = frame_start cycle).
    task automatic run_pass(input int overrun_at, output int cyc, output bit seen);
        @(negedge clk);
        bus.frame_start = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 300) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) bus.frame_start = 1'b0;
            if (cyc == 3) bus.doodle_y = 10'd0;
            if (overrun_at != 0 && cyc == overrun_at) bus.frame_start = 1'b1;
            if (overrun_at != 0 && cyc == overrun_at + 1) bus.frame_start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (all_outputs() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required 0", all_outputs());
        end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_scroll();
        int cyc, sh;
        bit seen;
        bus.doodle_y = 10'd400;
        push_expected(400, 16'h0, sh);
        run_pass(0, cyc, seen);
        tests_run++;
        if (!seen || cyc != 2) begin
            tests_failed++;
            $display("FAIL no_scroll_latency: got seen=%0d cycles=%0d, required cycles=2", seen, cyc);
        end
        tests_run++;
        if (bus.shift_amt !== 6'd0) begin
            tests_failed++;
            $display("FAIL no_scroll_shift: got %0d, required 0", bus.shift_amt);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.scroll_total !== 20'(exp_total) || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_scroll_total: got total=%0d busy=%b, required total=%0d busy=0",
                     bus.scroll_total, bus.busy, exp_total);
        end
    endtask

    task automatic test_small_scroll();
        int cyc, sh;
        bit seen;
        load_table(-162);
        bus.rnd = 16'h1234;
        bus.doodle_y = 10'd290;
        push_expected(290, 16'h1234, sh);
        run_pass(0, cyc, seen);
        tests_run++;
        if (!seen || cyc != 96) begin
            tests_failed++;
            $display("FAIL small_latency: got seen=%0d cycles=%0d, required cycles=96", seen, cyc);
        end
        tests_run++;
        if (bus.shift_amt !== 6'd10 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL small_shift: got shift=%0d busy=%b, required shift=10 busy=1",
                     bus.shift_amt, bus.busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.scroll_total !== 20'd10 || bus.busy !== 1'b0 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL small_total: got total=%0d busy=%b pending=%0d, required total=10 busy=0 pending=0",
                     bus.scroll_total, bus.busy, sb.size());
        end
    endtask

    task automatic test_clamp_recycle();
        int cyc, sh;
        bit seen;
        load_table(-150);
        bus.rnd = 16'h0000;
        bus.doodle_y = 10'd100;
        push_expected(100, 16'h0000, sh);
        run_pass(0, cyc, seen);
        tests_run++;
        if (!seen || cyc != 96 || bus.shift_amt !== 6'd32) begin
            tests_failed++;
            $display("FAIL clamp_pass: got cycles=%0d shift=%0d, required cycles=96 shift=32",
                     cyc, bus.shift_amt);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (mem[92] !== -11'sd148 || mem[90] !== -11'sd148 || mem[89] !== 11'sd752) begin
            tests_failed++;
            $display("FAIL clamp_table: got s90=%0d s92=%0d s89=%0d, required -148 -148 752",
                     mem[90], mem[92], mem[89]);
        end
        tests_run++;
        if (bus.scroll_total !== 20'd42 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL clamp_total: got total=%0d pending=%0d, required total=42 pending=0",
                     bus.scroll_total, sb.size());
        end
    endtask

    task automatic test_forced_activation();
        int cyc, sh;
        bit seen;
        bus.rnd = 16'hfff5;
        bus.doodle_y = 10'd100;
        push_expected(100, 16'hfff5, sh);
        run_pass(0, cyc, seen);
        @(posedge clk);
        #1;
        tests_run++;
        if (!seen || cyc != 96 || mem[87] !== -11'sd146 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL forced_act_pass: got cycles=%0d s87=%0d pending=%0d, required 96 -146 0",
                     cyc, mem[87], sb.size());
        end
        tests_run++;
        if (bus.scroll_total !== 20'(exp_total)) begin
            tests_failed++;
            $display("FAIL forced_act_total: got %0d, required %0d", bus.scroll_total, exp_total);
        end
    endtask

    task automatic test_overrun();
        int cyc, sh;
        bit seen;
        tests_run++;
        if (bus.frame_overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_initial: got %b, required 0", bus.frame_overrun);
        end
        bus.doodle_y = 10'd290;
        push_expected(290, bus.rnd, sh);
        run_pass(50, cyc, seen);
        tests_run++;
        if (!seen || cyc != 96 || bus.shift_amt !== 6'd10) begin
            tests_failed++;
            $display("FAIL overrun_pass: got cycles=%0d shift=%0d, required cycles=96 shift=10",
                     cyc, bus.shift_amt);
        end
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (bus.frame_overrun !== 1'b1 || bus.busy !== 1'b0 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL overrun_sticky: got overrun=%b busy=%b pending=%0d, required 1 0 0",
                     bus.frame_overrun, bus.busy, sb.size());
        end
        tests_run++;
        if (bus.scroll_total !== 20'(exp_total)) begin
            tests_failed++;
            $display("FAIL overrun_total: got %0d, required %0d", bus.scroll_total, exp_total);
        end
    endtask

    task automatic test_mid_reset();
        int sh, bad;
        bit found;
        load_table(-150);
        bus.doodle_y = 10'd100;
        push_expected(100, bus.rnd, sh);
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rd_idx == 7'd40) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL mid_reset_reach: got rd_idx=%0d, required 40 within 200 cycles", bus.rd_idx);
        end
        #1;
        rst_ni = 1'b0;
        sb.delete();
        exp_total = 0;
        #1;
        tests_run++;
        if (all_outputs() !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %h, required 0", all_outputs());
        end
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        bad = 0;
        for (int k = 40; k < Slots; k++) if (mem[k] !== init_y[k]) bad++;
        tests_run++;
        if (bad != 0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_table: got %0d changed slots >=40 busy=%b, required 0 and busy=0",
                     bad, bus.busy);
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.doodle_y    = 10'd400;
        bus.rnd         = 16'h0;
        test_reset();
        test_no_scroll();
        test_small_scroll();
        test_clamp_recycle();
        test_forced_activation();
        test_overrun();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
